// File: rtl/quire_to_posit_4_0_if.sv
// Handshake bundle between the quire accumulator, the posit converter and the result writer.
// master drives the quire side and downstream ready; slave is the converter's view.
interface quire_to_posit_4_0_if #(
  parameter int QUIRE_SIZE = 19
);
  logic                  rts_i;
  logic                  rtr_o;
  logic                  sow_i;
  logic                  eow_i;
  logic [QUIRE_SIZE-1:0] data_i;
  logic                  sign_i;
  logic                  zero_i;
  logic                  NaR_i;
  logic                  rtr_i;
  logic                  rts_o;
  logic [3:0]            posit_o;
  logic                  NaR_o;
  logic                  zero_o;

  modport master (
    output rts_i, sow_i, eow_i, data_i, sign_i, zero_i, NaR_i, rtr_i,
    input  rtr_o, rts_o, posit_o, NaR_o, zero_o
  );

  modport slave (
    input  rts_i, sow_i, eow_i, data_i, sign_i, zero_i, NaR_i, rtr_i,
    output rtr_o, rts_o, posit_o, NaR_o, zero_o
  );
endinterface

// File: rtl/quire_to_posit_4_0.sv
// Quire -> posit<4,0> converter: 3-stage stallable pipeline (magnitude, leading-one, encode/round)
// with a one-entry skid latch covering the registered rtr_o.
module quire_to_posit_4_0 #(
  parameter int LOG_NB_ACCUM = 10,
  parameter bit FILTER_EOW   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  quire_to_posit_4_0_if.slave bus
);
  localparam int QUIRE_SIZE = 9 + LOG_NB_ACCUM;
  localparam int MAG_W      = QUIRE_SIZE + 1;
  localparam int POS_W      = $clog2(MAG_W);
  localparam int SC_W       = POS_W + 1;
  localparam logic signed [SC_W-1:0] SC_MAX = SC_W'(2);
  localparam logic signed [SC_W-1:0] SC_MIN = SC_W'(-3);

  typedef struct packed {
    logic                  eow;
    logic                  nar;
    logic                  zero;
    logic [QUIRE_SIZE-1:0] dat;
  } beat_t;

  typedef struct packed {
    logic             vld;
    logic             nar;
    logic             zero;
    logic             neg;
    logic [MAG_W-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic            vld;
    logic            nar;
    logic            zero;
    logic            neg;
    logic [SC_W-1:0] scale;
    logic [1:0]      grd;
    logic            stk;
  } s2_t;

  typedef struct packed {
    logic       vld;
    logic       nar;
    logic       zero;
    logic [3:0] posit;
  } out_t;

  logic  rtr_d, rtr_q;
  logic  lat_vld_d, lat_vld_q;
  beat_t lat_d, lat_q;
  s1_t   s1_d, s1_q;
  s2_t   s2_d, s2_q;
  out_t  out_d, out_q;

  logic  process_en;
  logic  recv;
  beat_t in_beat;
  beat_t src;
  logic  src_vld;

  assign process_en = bus.rtr_i | ~out_q.vld;
  assign recv       = bus.rts_i & rtr_q;
  assign in_beat    = {bus.eow_i, bus.NaR_i, bus.zero_i, bus.data_i};
  // A held beat always goes ahead of whatever arrives alongside it.
  assign src        = lat_vld_q ? lat_q : in_beat;
  assign src_vld    = lat_vld_q | recv;
  assign rtr_d      = process_en;

  always_comb begin
    lat_vld_d = lat_vld_q;
    lat_d     = lat_q;
    if (process_en) begin
      lat_vld_d = lat_vld_q & recv;
      if (lat_vld_q & recv) begin
        lat_d = in_beat;
      end
    end else if (recv & ~lat_vld_q) begin
      lat_vld_d = 1'b1;
      lat_d     = in_beat;
    end
  end

  logic [MAG_W-1:0] ext;

  // One extra magnitude bit keeps the most negative quire exact.
  always_comb begin
    s1_d = s1_q;
    ext  = {src.dat[QUIRE_SIZE-1], src.dat};
    if (process_en) begin
      s1_d.vld  = src_vld & (~FILTER_EOW | src.eow);
      s1_d.nar  = src.nar;
      s1_d.zero = src.zero;
      s1_d.neg  = ext[MAG_W-1];
      s1_d.mag  = ext[MAG_W-1] ? (~ext + 1'b1) : ext;
    end
  end

  logic [POS_W-1:0] lead;
  logic [MAG_W-1:0] norm;

  always_comb begin
    s2_d = s2_q;
    lead = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (s1_q.mag[i]) begin
        lead = POS_W'(i);
      end
    end
    norm = s1_q.mag << (POS_W'(MAG_W - 1) - lead);
    if (process_en) begin
      s2_d.vld   = s1_q.vld;
      s2_d.nar   = s1_q.nar;
      s2_d.neg   = s1_q.neg;
      s2_d.zero  = s1_q.zero | (s1_q.mag == '0);
      s2_d.scale = $signed({1'b0, lead}) - SC_W'(4);
      s2_d.grd   = norm[MAG_W-2 -: 2];
      s2_d.stk   = |norm[MAG_W-4:0];
    end
  end

  logic [2:0] body_t;
  logic [2:0] body_r;
  logic       rnd_g;
  logic       rnd_s;
  logic [3:0] mag_p;
  logic [3:0] posit_v;

  // Only scales -2..1 need rounding; the body never rounds past 111, so NaR is unreachable.
  always_comb begin
    out_d  = out_q;
    body_t = 3'b001;
    rnd_g  = 1'b0;
    rnd_s  = 1'b0;
    if ($signed(s2_q.scale) >= SC_MAX) begin
      body_t = 3'b111;
    end else if ($signed(s2_q.scale) <= SC_MIN) begin
      body_t = 3'b001;
    end else begin
      unique case (s2_q.scale[1:0])
        2'b01: begin
          body_t = 3'b110;
          rnd_g  = s2_q.grd[1];
          rnd_s  = s2_q.grd[0] | s2_q.stk;
        end
        2'b00: begin
          body_t = {2'b10, s2_q.grd[1]};
          rnd_g  = s2_q.grd[0];
          rnd_s  = s2_q.stk;
        end
        2'b11: begin
          body_t = {2'b01, s2_q.grd[1]};
          rnd_g  = s2_q.grd[0];
          rnd_s  = s2_q.stk;
        end
        default: begin
          body_t = 3'b001;
          rnd_g  = s2_q.grd[1];
          rnd_s  = s2_q.grd[0] | s2_q.stk;
        end
      endcase
    end
    body_r  = body_t + {2'b00, rnd_g & (rnd_s | body_t[0])};
    mag_p   = {1'b0, body_r};
    posit_v = s2_q.neg ? (4'b0000 - mag_p) : mag_p;
    if (process_en) begin
      out_d.vld   = s2_q.vld;
      out_d.nar   = s2_q.nar;
      out_d.zero  = ~s2_q.nar & s2_q.zero;
      out_d.posit = s2_q.nar ? 4'b1000 : (s2_q.zero ? 4'b0000 : posit_v);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_q     <= 1'b0;
      lat_vld_q <= 1'b0;
      lat_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_q     <= '0;
    end else begin
      rtr_q     <= rtr_d;
      lat_vld_q <= lat_vld_d;
      lat_q     <= lat_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      out_q     <= out_d;
    end
  end

  assign bus.rtr_o   = rtr_q;
  assign bus.rts_o   = out_q.vld;
  assign bus.posit_o = out_q.posit;
  assign bus.NaR_o   = out_q.nar;
  assign bus.zero_o  = out_q.zero;
endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Directed bench: exact/rounded values, flags, eow filtering (both settings), backpressure,
// skid latch, and mid-stream reset, all scored against hand-computed posits.
module tb_quire_to_posit_4_0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quire_to_posit_4_0_if #(.QUIRE_SIZE(19)) qif ();
  quire_to_posit_4_0_if #(.QUIRE_SIZE(19)) qif0 ();

  quire_to_posit_4_0 #(.LOG_NB_ACCUM(10), .FILTER_EOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(qif.slave)
  );
  quire_to_posit_4_0 #(.LOG_NB_ACCUM(10), .FILTER_EOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(qif0.slave)
  );

  assign qif0.rts_i  = qif.rts_i;
  assign qif0.sow_i  = qif.sow_i;
  assign qif0.eow_i  = qif.eow_i;
  assign qif0.data_i = qif.data_i;
  assign qif0.sign_i = qif.sign_i;
  assign qif0.zero_i = qif.zero_i;
  assign qif0.NaR_i  = qif.NaR_i;
  assign qif0.rtr_i  = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  int n0 = 0;
  logic [5:0] exp_q[$];
  logic [5:0] q0[$];
  bit bp_on = 1'b0;
  bit win_on = 1'b0;
  bit hold_vld = 1'b0;
  logic [5:0] hold_val;

  // {NaR, zero, posit}
  logic [18:0] vd [20] = '{19'd16, 19'd24, 19'd8, 19'd4, 19'd32, 19'd64, 19'h7FFF0, 19'd20,
                           19'd21, 19'd48, 19'd49, 19'd1, 19'd1000, 19'h7FC18, 19'h40000,
                           19'd16, 19'd16, 19'd16, 19'd0, 19'd6};
  logic vn [20] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,1,0,0};
  logic vz [20] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0,0};
  logic [5:0] ve [20] = '{6'h04, 6'h05, 6'h02, 6'h01, 6'h06, 6'h07, 6'h0C, 6'h04,
                          6'h05, 6'h06, 6'h07, 6'h01, 6'h07, 6'h09, 6'h09,
                          6'h28, 6'h10, 6'h28, 6'h10, 6'h02};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [18:0] d, input logic eow, input logic nar, input logic zr,
                      input logic [5:0] e);
    int w;
    qif.rts_i  = 1'b1;
    qif.data_i = d;
    qif.eow_i  = eow;
    qif.NaR_i  = nar;
    qif.zero_i = zr;
    qif.sign_i = d[18];
    w = 0;
    @(negedge clk);
    while (!qif.rtr_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("send_timeout", 0, 1);
    if (eow) exp_q.push_back(e);
    @(posedge clk);
    #1;
    qif.rts_i = 1'b0;
    qif.sow_i = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_on) qif.rtr_i = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic [5:0] got;
    got = {qif.NaR_o, qif.zero_o, qif.posit_o};
    if (hold_vld && rst_n) chk("hold_stable", {qif.rts_o, got}, {1'b1, hold_val});
    hold_vld = 1'b0;
    if (rst_n && qif.rts_o) begin
      if (qif.rtr_i) begin
        n_out++;
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else chk("out_value", got, exp_q.pop_front());
      end else begin
        hold_vld = 1'b1;
        hold_val = got;
      end
    end
  end

  always @(negedge clk) begin
    if (win_on && rst_n && qif0.rts_o) begin
      n0++;
      if (q0.size() == 0) chk("nofilt_spurious", 1, 0);
      else chk("nofilt_value", {qif0.NaR_o, qif0.zero_o, qif0.posit_o}, q0.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int mark;
    qif.rts_i = 1'b0; qif.sow_i = 1'b0; qif.eow_i = 1'b0; qif.data_i = '0;
    qif.sign_i = 1'b0; qif.zero_i = 1'b0; qif.NaR_i = 1'b0; qif.rtr_i = 1'b1;

    #12;
    chk("reset_outputs", {qif.rts_o, qif.rtr_o, qif.NaR_o, qif.zero_o, qif.posit_o}, 0);
    #11 rst_n = 1'b1;
    @(negedge clk);
    chk("rtr_after_reset", qif.rtr_o, 1);
    @(posedge clk); #1;

    // Latency of a lone beat, then the rest of the directed values.
    qif.sow_i = 1'b1;
    send(vd[0], 1'b1, vn[0], vz[0], ve[0]);
    lat = 0;
    while (!qif.rts_o && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    @(posedge clk); #1;
    for (int i = 1; i < 20; i++) send(vd[i], 1'b1, vn[i], vz[i], ve[i]);
    idle(10);

    // Full pipe stalled: rtr_o drops a cycle later; the beat accepted meanwhile sits in the latch.
    send(vd[0], 1'b1, 1'b0, 1'b0, ve[0]);
    send(vd[1], 1'b1, 1'b0, 1'b0, ve[1]);
    send(vd[2], 1'b1, 1'b0, 1'b0, ve[2]);
    qif.rtr_i = 1'b0;
    #1;
    chk("rtr_before_fall", qif.rtr_o, 1);
    send(vd[4], 1'b1, 1'b0, 1'b0, ve[4]);
    @(negedge clk);
    chk("rtr_after_fall", qif.rtr_o, 0);
    idle(3);
    qif.rtr_i = 1'b1;
    idle(10);

    // Random downstream backpressure with a mix of eow and dropped beats.
    bp_on = 1'b1;
    for (int i = 0; i < 40; i++) send(vd[i % 8], 1'((i % 3) != 1), 1'b0, 1'b0, ve[i % 8]);
    bp_on = 1'b0;
    qif.rtr_i = 1'b1;
    idle(20);
    chk("bp_drained", exp_q.size(), 0);

    // 1024-beat window, eow only on the last beat.
    idle(5);
    mark = n_out;
    win_on = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      q0.push_back(ve[i % 8]);
      qif.sow_i = (i == 0);
      send(vd[i % 8], 1'(i == 1023), 1'b0, 1'b0, ve[i % 8]);
    end
    idle(10);
    win_on = 1'b0;
    chk("nofilt_count", n0, 1024);
    chk("filt_count", n_out - mark, 1);

    // Reset with three beats in flight.
    send(vd[5], 1'b1, 1'b0, 1'b0, ve[5]);
    send(vd[6], 1'b1, 1'b0, 1'b0, ve[6]);
    send(vd[7], 1'b1, 1'b0, 1'b0, ve[7]);
    rst_n = 1'b0;
    #1;
    chk("reset_mid", {qif.rts_o, qif.rtr_o, qif.NaR_o, qif.zero_o, qif.posit_o}, 0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    mark = n_out;
    idle(10);
    chk("no_stale", n_out - mark, 0);
    send(vd[13], 1'b1, 1'b0, 1'b0, ve[13]);

    lat = 0;
    while (exp_q.size() != 0 && lat < 50) begin
      @(posedge clk);
      lat++;
    end
    #1;
    chk("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
